// File: rtl/prbs7_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs7_checker
// Description : Serial PRBS7 (x^7+x^6+1) checker. It self-synchronises to the
//               incoming stream and then free-runs a local reference. It
//               reports lock status, a per-error pulse and a saturating error
//               count.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs7_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 din,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [1:0] c_ST_SEED = 2'd0;
    localparam logic [1:0] c_ST_HUNT = 2'd1;
    localparam logic [1:0] c_ST_LOCK = 2'd2;

    localparam logic [7:0]           c_LOCK_CNT = 8'(LOCK_CNT);
    localparam logic [7:0]           c_UNLOCK   = 8'(UNLOCK_ERRS);
    localparam logic [ERR_CNT_W-1:0] c_CNT_MAX  = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] c_CNT_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [6:0]           r_sr;
    logic [2:0]           r_fill;
    logic [7:0]           r_match;
    logic [7:0]           r_miss;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [1:0]           w_state_nxt;
    logic [6:0]           w_sr_nxt;
    logic [2:0]           w_fill_nxt;
    logic [7:0]           w_match_nxt;
    logic [7:0]           w_miss_nxt;
    logic                 w_err_pulse_nxt;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

    // Expected bit comes from the two oldest taps of the pre-update register.
    logic       w_exp;
    logic [6:0] w_sr_in;
    logic [7:0] w_match_inc;
    logic [7:0] w_miss_inc;

    assign w_exp       = r_sr[6] ^ r_sr[5];
    assign w_sr_in     = {r_sr[5:0], din};
    assign w_match_inc = r_match + 8'd1;
    assign w_miss_inc  = r_miss + 8'd1;

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

    // State register: all state and registered outputs, async reset to SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_SEED;
            r_sr        <= 7'd0;
            r_fill      <= 3'd0;
            r_match     <= 8'd0;
            r_miss      <= 8'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_fill      <= w_fill_nxt;
            r_match     <= w_match_nxt;
            r_miss      <= w_miss_nxt;
            r_locked    <= (w_state_nxt == c_ST_LOCK);
            r_err_pulse <= w_err_pulse_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    // Next-state logic: seed the register, hunt for a run of matches, then
    // free-run the reference and count mismatches while locked.
    always_comb begin
        w_state_nxt     = r_state;
        w_sr_nxt        = r_sr;
        w_fill_nxt      = r_fill;
        w_match_nxt     = r_match;
        w_miss_nxt      = r_miss;
        w_err_pulse_nxt = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;

        if (en) begin
            case (r_state)
                c_ST_SEED: begin
                    w_sr_nxt   = w_sr_in;
                    w_fill_nxt = r_fill + 3'd1;
                    if (r_fill == 3'd6) begin
                        w_state_nxt = c_ST_HUNT;
                        w_match_nxt = 8'd0;
                    end
                end
                c_ST_HUNT: begin
                    w_sr_nxt = w_sr_in;
                    // An all-zero register is the PRBS lock-up state; never
                    // let it count toward lock.
                    if ((din == w_exp) && (w_sr_in != 7'd0)) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == c_LOCK_CNT) begin
                            w_state_nxt = c_ST_LOCK;
                            w_miss_nxt  = 8'd0;
                        end
                    end else begin
                        w_match_nxt = 8'd0;
                    end
                end
                c_ST_LOCK: begin
                    // Feed back the expected bit so one corrupt input bit
                    // produces exactly one error.
                    w_sr_nxt = {r_sr[5:0], w_exp};
                    if (din != w_exp) begin
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_cnt != c_CNT_MAX) begin
                            w_err_cnt_nxt = r_err_cnt + c_CNT_ONE;
                        end
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == c_UNLOCK) begin
                            w_state_nxt = c_ST_SEED;
                            w_fill_nxt  = 3'd0;
                        end
                    end else begin
                        w_miss_nxt = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_SEED;
                    w_fill_nxt  = 3'd0;
                end
            endcase
        end

        // Clear wins over a simultaneous increment.
        if (clr_err) begin
            w_err_cnt_nxt = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs7_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs7_checker
// Description : Self-checking bench for prbs7_checker: table-driven segments,
//               hand-written corner sequences and a randomized phase, all
//               compared against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs7_checker;

    localparam int LCK = 16;
    localparam int ULK = 4;
    localparam int CW  = 4;

    localparam int K_PRBS  = 0;
    localparam int K_ZERO  = 1;
    localparam int K_RESET = 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          din;
    logic          clr_err;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_cnt;

    prbs7_checker #(
        .LOCK_CNT   (LCK),
        .UNLOCK_ERRS(ULK),
        .ERR_CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .din      (din),
        .clr_err  (clr_err),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: the last seven reference bits kept as a queue,
    // oldest first; mode 0=SEED, 1=HUNT, 2=LOCK.
    bit   q_hist[$];
    int   m_mode;
    int   m_fill;
    int   m_run;
    int   m_bad;
    bit   m_locked;
    bit   m_pulse;
    int   m_cnt;

    logic [6:0] gen;
    int         seg_pulses;

    typedef struct {
        int   kind;
        int   nbits;
        int   ninv;
        bit   gap;
        bit   clr;
        bit   reseed;
        logic exp_locked;
        int   exp_cnt;
        int   exp_pulses;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(int kind, int nbits, int ninv, bit gap, bit clr,
                                bit reseed, logic el, int ec, int ep);
        vec_t v;
        v.kind = kind; v.nbits = nbits; v.ninv = ninv; v.gap = gap; v.clr = clr;
        v.reseed = reseed; v.exp_locked = el; v.exp_cnt = ec; v.exp_pulses = ep;
        return v;
    endfunction

    function automatic void model_reset();
        q_hist.delete();
        for (int i = 0; i < 7; i++) q_hist.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_run = 0; m_bad = 0;
        m_locked = 1'b0; m_pulse = 1'b0; m_cnt = 0;
    endfunction

    function automatic void model_step(bit v, bit b, bit c);
        bit pred;
        bit nz;
        m_pulse = 1'b0;
        if (v) begin
            pred = q_hist[0] ^ q_hist[1];
            if (m_mode == 2) begin
                q_hist.push_back(pred);
                void'(q_hist.pop_front());
                if (b != pred) begin
                    m_pulse = 1'b1;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                    m_bad++;
                    if (m_bad == ULK) begin
                        m_mode = 0;
                        m_fill = 0;
                    end
                end else begin
                    m_bad = 0;
                end
            end else begin
                q_hist.push_back(b);
                void'(q_hist.pop_front());
                if (m_mode == 0) begin
                    m_fill++;
                    if (m_fill == 7) begin
                        m_mode = 1;
                        m_run  = 0;
                    end
                end else begin
                    nz = 1'b0;
                    foreach (q_hist[i]) if (q_hist[i]) nz = 1'b1;
                    if (b == pred && nz) begin
                        m_run++;
                        if (m_run == LCK) begin
                            m_mode = 2;
                            m_bad  = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            end
        end
        if (c) m_cnt = 0;
        m_locked = (m_mode == 2);
    endfunction

    function automatic bit next_bit();
        bit b;
        b   = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit b, input bit c);
        @(negedge clk);
        en = v; din = b; clr_err = c;
        model_step(v, b, c);
        @(posedge clk);
        #1;
        chk("locked", {31'd0, locked}, int'(m_locked));
        chk("err_pulse", {31'd0, err_pulse}, int'(m_pulse));
        chk("err_cnt", {{(32-CW){1'b0}}, err_cnt}, m_cnt);
        if (err_pulse === 1'b1) seg_pulses++;
    endtask

    task automatic send(input bit inv, input bit gap, input bit c);
        bit b;
        b = next_bit() ^ inv;
        drive(1'b1, b, c);
        if (gap) begin
            repeat (2) drive(1'b0, bit'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; en = 1'b0; clr_err = 1'b0;
        #1;
        chk("rst locked", {31'd0, locked}, 0);
        chk("rst err_pulse", {31'd0, err_pulse}, 0);
        chk("rst err_cnt", {{(32-CW){1'b0}}, err_cnt}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; din = 1'b0; clr_err = 1'b0;
        gen = 7'h7F;
        model_reset();
        #12;
        chk("init locked", {31'd0, locked}, 0);
        chk("init err_pulse", {31'd0, err_pulse}, 0);
        chk("init err_cnt", {{(32-CW){1'b0}}, err_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //          kind     nbits ninv gap clr rsd  lock cnt pulses
        tbl[0]  = mk(K_PRBS,  22,  0,   0,  0,  1,   0,   0,  0);
        tbl[1]  = mk(K_PRBS,  1,   0,   0,  0,  0,   1,   0,  0);
        tbl[2]  = mk(K_PRBS,  177, 0,   0,  0,  0,   1,   0,  0);
        tbl[3]  = mk(K_PRBS,  1,   1,   0,  0,  0,   1,   1,  1);
        tbl[4]  = mk(K_PRBS,  100, 0,   0,  1,  0,   1,   0,  0);
        tbl[5]  = mk(K_PRBS,  4,   4,   0,  0,  0,   0,   4,  4);
        tbl[6]  = mk(K_PRBS,  22,  0,   0,  0,  0,   0,   4,  0);
        tbl[7]  = mk(K_PRBS,  1,   0,   0,  0,  0,   1,   4,  0);
        tbl[8]  = mk(K_RESET, 0,   0,   0,  0,  0,   0,   0,  0);
        tbl[9]  = mk(K_ZERO,  300, 0,   0,  0,  0,   0,   0,  0);
        tbl[10] = mk(K_PRBS,  22,  0,   1,  0,  1,   0,   0,  0);
        tbl[11] = mk(K_PRBS,  1,   0,   1,  0,  0,   1,   0,  0);

        foreach (tbl[s]) begin
            seg_pulses = 0;
            if (tbl[s].reseed) gen = 7'h7F;
            if (tbl[s].kind == K_RESET) begin
                async_reset();
            end else begin
                for (int i = 0; i < tbl[s].nbits; i++) begin
                    if (tbl[s].kind == K_ZERO) drive(1'b1, 1'b0, 1'b0);
                    else send(i < tbl[s].ninv, tbl[s].gap, tbl[s].clr && (i == 0));
                end
            end
            chk($sformatf("seg%0d locked", s), {31'd0, locked}, int'(tbl[s].exp_locked));
            chk($sformatf("seg%0d err_cnt", s), {{(32-CW){1'b0}}, err_cnt}, tbl[s].exp_cnt);
            chk($sformatf("seg%0d pulses", s), 32'(seg_pulses), tbl[s].exp_pulses);
        end

        // Saturation: 20 isolated errors on a 4-bit counter.
        seg_pulses = 0;
        repeat (20) begin
            send(1'b1, 1'b0, 1'b0);
            repeat (6) send(1'b0, 1'b0, 1'b0);
        end
        chk("sat err_cnt", {{(32-CW){1'b0}}, err_cnt}, 15);
        chk("sat locked", {31'd0, locked}, 1);
        chk("sat pulses", 32'(seg_pulses), 20);

        // Clear coinciding with a bad bit: pulse fires, count reads zero.
        send(1'b1, 1'b0, 1'b1);
        chk("clr pulse", {31'd0, err_pulse}, 1);
        chk("clr err_cnt", {{(32-CW){1'b0}}, err_cnt}, 0);
        repeat (6) send(1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        chk("post clr err_cnt", {{(32-CW){1'b0}}, err_cnt}, 1);
        repeat (2) begin
            repeat (6) send(1'b0, 1'b0, 1'b0);
            send(1'b1, 1'b0, 1'b0);
        end
        repeat (3) send(1'b0, 1'b0, 1'b0);
        chk("pre-rst err_cnt", {{(32-CW){1'b0}}, err_cnt}, 3);
        chk("pre-rst locked", {31'd0, locked}, 1);

        // Reset while locked, then relock from a fresh stream.
        async_reset();
        gen = 7'h7F;
        repeat (22) send(1'b0, 1'b0, 1'b0);
        chk("relock early", {31'd0, locked}, 0);
        send(1'b0, 1'b0, 1'b0);
        chk("relock", {31'd0, locked}, 1);

        // Randomized phase: sparse corruption, random qualifier and clears.
        for (int i = 0; i < 600; i++) begin
            bit v;
            bit b;
            v = ($urandom_range(0, 3) != 0);
            if (v) b = next_bit() ^ ($urandom_range(0, 19) == 0);
            else   b = bit'($urandom_range(0, 1));
            drive(v, b, $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Serial PRBS7 checker that consumes the registered bit stream from the single-bit flop stage (din is driven from that stage's q).
- Self-synchronises to the x^7+x^6+1 sequence and then free-runs a local reference.
- Reports lock status, per-error pulses and a saturating error count to the cocotb environment.
- Instantiated in tb_top alongside the flop stage, on the same clock and reset.

Parameters:
- LOCK_CNT, 16: consecutive matching valid bits required in HUNT before declaring lock (range 1..255).
- UNLOCK_ERRS, 4: consecutive mismatching valid bits in LOCK that force loss of lock (range 1..255).
- ERR_CNT_W, 16: width of the error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  din qualifier; the bit is consumed only when en=1.
- din  input  1  serial data bit (from the flop stage q).
- clr_err  input  1  synchronous clear of err_cnt.
- locked  output  1  high while in LOCK.
- err_pulse  output  1  one-cycle pulse per mismatching valid bit while in LOCK.
- err_cnt  output  ERR_CNT_W  saturating count of LOCK-state mismatches.

Behaviour:
- Reset (async assert, sync release): state=SEED, sr=0, fill/match/miss counters=0, locked=0, err_pulse=0, err_cnt=0.
- Reset has priority over everything and can be applied mid-operation; the block restarts from SEED.
- sr[6:0] shifts left on each valid bit. Expected bit e = sr[6]^sr[5], computed from the pre-update sr.
- en=0: all state and counters hold; err_pulse=0 in that cycle.
- SEED:
  - Each valid bit: sr <= {sr[5:0],din}, fill++.
  - On the 7th valid bit, go to HUNT with match=0.
- HUNT:
  - Each valid bit: sr <= {sr[5:0],din}.
  - Match (din==e) and the updated sr is not all-zero: match++.
  - Otherwise match=0. An all-zero register never counts toward lock, so an all-zero stream cannot lock.
  - When match reaches LOCK_CNT, go to LOCK with miss=0.
- LOCK:
  - Each valid bit: sr <= {sr[5:0],e}. The local reference free-runs, so a single corrupted bit yields exactly one error.
  - din!=e: err_pulse=1 next cycle, err_cnt++ (saturating at all-ones), miss++.
  - din==e: miss=0.
  - When miss reaches UNLOCK_ERRS, go to SEED with fill=0. The bit that caused the unlock is counted as an error.
- Outputs are registered.
  - locked rises on the edge that enters LOCK, i.e. it is visible the cycle after the LOCK_CNT-th matching bit is sampled.
  - locked falls on the edge that leaves LOCK.
  - err_pulse and err_cnt update on the same edge that samples the bad bit; both are visible the following cycle.
- Mismatches in SEED/HUNT never affect err_pulse or err_cnt.
- clr_err=1: err_cnt <= 0 on that edge. This takes priority over a simultaneous increment. err_pulse still fires for that error, but the count shows 0.
- clr_err does not affect state, sr, match or miss.
- Latency from valid stream start (clean PRBS7, en=1 every cycle): locked high after 7+LOCK_CNT valid bits plus 1 cycle.

Test Plan:
- Clean lock: reset, then PRBS7 from seed 7'h7F, en=1 continuously, 200 bits.
  - locked=0 through bit 23; locked=1 the cycle after bit 23 and stays high.
  - err_cnt=0; err_pulse never asserts.
- Single error: after lock, invert one bit.
  - Exactly one err_pulse; err_cnt=1; locked stays 1; no further errors over the next 100 bits.
- Loss of lock: after lock, invert 4 consecutive bits.
  - 4 err_pulses; err_cnt=4; locked=0 after the 4th bit.
  - Relock 23 valid bits later; err_cnt stays 4.
- All-zero and gapped stream: drive din=0 for 300 bits, so locked never asserts.
  - Then drive PRBS7 with en toggling 1,0,0,1...; locked asserts after exactly 23 valid bits regardless of the gaps.
- Saturation and clear: ERR_CNT_W=4.
  - 20 isolated errors (each separated by at least 5 good bits): err_cnt=15 and locked stays 1.
  - clr_err pulsed in the same cycle as a bad bit: err_pulse=1, err_cnt=0.
  - Next error: err_cnt=1.
- Reset mid-operation: assert rst_n=0 while locked with err_cnt=3.
  - locked, err_pulse and err_cnt go to 0 asynchronously.
  - After release, the block relocks in 23 valid bits.
